// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment driver with per-slot dead time and tear-free frame updates.
// Define SEG7_LZB_EN to enable leading-zero blanking of digits 3..1.
module seg7_scan #(
  parameter int WAIT  = 16,
  parameter int BLANK = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_value,
  input  logic [3:0]  i_dp,
  input  logic        i_load,
  input  logic        i_en,
  output logic [3:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic        o_frame
);

  localparam logic [WAIT-1:0] CNT_MAX = '1;
  localparam logic [WAIT-1:0] BLANK_C = WAIT'(BLANK);

  typedef enum logic {
    PH_BLANK,
    PH_ON
  } phase_t;

  logic [WAIT-1:0] cnt;
  logic [1:0]      idx;
  logic [15:0]     act_val;
  logic [3:0]      act_dp;
  logic [15:0]     pend_val;
  logic [3:0]      pend_dp;
  logic            pend_flag;

  phase_t          phase;
  logic            slot_end;
  logic            boundary;
  logic [3:0]      nib;
  logic            lit;
  logic [3:0]      an_nxt;
  logic [6:0]      seg_nxt;
  logic            dp_nxt;

  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

`ifdef SEG7_LZB_EN
  // A digit is suppressed when it and every higher nibble are zero and its dp is off.
  function automatic logic lz_blank(input logic [15:0] v, input logic [3:0] d,
                                    input logic [1:0] i);
    logic zero;
    logic r;
    zero = 1'b1;
    r    = 1'b0;
    for (int n = 3; n >= 1; n--) begin
      zero = zero & (v[n*4 +: 4] == 4'h0);
      if (i == 2'(n)) r = zero & ~d[n];
    end
    return r;
  endfunction
`endif

  always_comb begin
    slot_end = (cnt == CNT_MAX);
    boundary = slot_end && (idx == 2'd3);
    phase    = (cnt < BLANK_C) ? PH_BLANK : PH_ON;
    nib      = act_val[{idx, 2'b00} +: 4];
    lit      = (phase == PH_ON) && i_en;
`ifdef SEG7_LZB_EN
    lit      = lit && !lz_blank(act_val, act_dp, idx);
`endif
    an_nxt   = 4'hF;
    if (lit) an_nxt[idx] = 1'b0;
    seg_nxt  = (phase == PH_ON) ? hex_decode(nib) : 7'h7F;
    dp_nxt   = (phase == PH_ON) ? ~act_dp[idx] : 1'b1;
  end

  // Scan position and frame marker
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt     <= '0;
      idx     <= 2'd0;
      o_frame <= 1'b0;
    end else begin
      cnt     <= cnt + 1'b1;
      if (slot_end) idx <= idx + 2'd1;
      o_frame <= boundary;
    end
  end

  // Pending/active double buffer; a load on the boundary edge wins the flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      act_val   <= '0;
      act_dp    <= '0;
      pend_val  <= '0;
      pend_dp   <= '0;
      pend_flag <= 1'b0;
    end else begin
      if (boundary && pend_flag) begin
        act_val <= pend_val;
        act_dp  <= pend_dp;
      end
      if (i_load) begin
        pend_val  <= i_value;
        pend_dp   <= i_dp;
        pend_flag <= 1'b1;
      end else if (boundary) begin
        pend_flag <= 1'b0;
      end
    end
  end

  // Registered display outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_an  <= 4'hF;
      o_seg <= 7'h7F;
      o_dp  <= 1'b1;
    end else begin
      o_an  <= an_nxt;
      o_seg <= seg_nxt;
      o_dp  <= dp_nxt;
    end
  end

endmodule
